// File: rtl/simple_pkg.sv
// Shared encodings for the simple multi-cycle core: opcode fields, branch
// sub-codes, write-back selects and the one-hot phase state.
package simple_pkg;

   localparam logic [1:0] OP1_LD  = 2'b00;
   localparam logic [1:0] OP1_ST  = 2'b01;
   localparam logic [1:0] OP1_BR  = 2'b10;
   localparam logic [1:0] OP1_ALU = 2'b11;

   localparam logic [3:0] OP3_ADD = 4'b0000;
   localparam logic [3:0] OP3_SUB = 4'b0001;
   localparam logic [3:0] OP3_AND = 4'b0010;
   localparam logic [3:0] OP3_OR  = 4'b0011;
   localparam logic [3:0] OP3_XOR = 4'b0100;
   localparam logic [3:0] OP3_CMP = 4'b0101;
   localparam logic [3:0] OP3_MOV = 4'b0110;
   localparam logic [3:0] OP3_SLL = 4'b1000;
   localparam logic [3:0] OP3_SLR = 4'b1001;
   localparam logic [3:0] OP3_SRL = 4'b1010;
   localparam logic [3:0] OP3_SRA = 4'b1011;
   localparam logic [3:0] OP3_IN  = 4'b1100;
   localparam logic [3:0] OP3_OUT = 4'b1101;
   localparam logic [3:0] OP3_HLT = 4'b1111;

   localparam logic [2:0] BR_LI  = 3'b000;
   localparam logic [2:0] BR_B   = 3'b100;
   localparam logic [2:0] BR_BCC = 3'b111;

   localparam logic [2:0] COND_BE  = 3'b000;
   localparam logic [2:0] COND_BLT = 3'b001;
   localparam logic [2:0] COND_BLE = 3'b010;
   localparam logic [2:0] COND_BNE = 3'b011;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_IMM = 2'b10;
   localparam logic [1:0] WB_IN  = 2'b11;

   // Encoded directly as the {P5..P1} phase vector; HALT is all-zero.
   typedef enum logic [4:0] {
      PH_HALT = 5'b00000,
      PH_P1   = 5'b00001,
      PH_P2   = 5'b00010,
      PH_P3   = 5'b00100,
      PH_P4   = 5'b01000,
      PH_P5   = 5'b10000
   } phase_e;

   function automatic logic op3_sets_flags(input logic [3:0] op3);
      logic r;
      case (op3)
         OP3_ADD, OP3_SUB, OP3_AND, OP3_OR, OP3_XOR, OP3_CMP, OP3_MOV,
         OP3_SLL, OP3_SLR, OP3_SRL, OP3_SRA: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic op3_writes_rf(input logic [3:0] op3);
      logic r;
      case (op3)
         OP3_ADD, OP3_SUB, OP3_AND, OP3_OR, OP3_XOR, OP3_MOV,
         OP3_SLL, OP3_SLR, OP3_SRL, OP3_SRA, OP3_IN: r = 1'b1;
         default:                                   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/simple_branch_cond.sv
// Combinational branch-condition evaluator: architectural {S,Z,C,V} plus the
// 3-bit condition field give the taken decision.
module simple_branch_cond
   import simple_pkg::*;
(
   input  logic [3:0] szcv,
   input  logic [2:0] cond,
   output logic       taken
);

   logic s_s;
   logic z_s;
   logic v_s;
   logic unused_c_s;

   assign s_s        = szcv[3];
   assign z_s        = szcv[2];
   assign unused_c_s = szcv[1];
   assign v_s        = szcv[0];

   // Condition decode; codes 100-111 are reserved and never taken.
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_BE:  taken = z_s;
         COND_BLT: taken = s_s ^ v_s;
         COND_BLE: taken = z_s | (s_s ^ v_s);
         COND_BNE: taken = ~z_s;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/simple_phase_ctrl.sv
// Five-phase control unit (fetch, decode, execute, memory, writeback) with HALT.
// Define IMEM_WAIT_EN to add imem_ready, which stretches P1 until memory is ready.
module simple_phase_ctrl
   import simple_pkg::*;
#(
   parameter logic [15:0] PC_RESET = 16'h0000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] imem_rdata,
`ifdef IMEM_WAIT_EN
   input  logic        imem_ready,
`endif
   input  logic [3:0]  alu_szcv,
   input  logic        run_i,
   output logic [15:0] pc,
   output logic [15:0] ir,
   output logic [4:0]  phase,
   output logic [1:0]  alu_op1,
   output logic [3:0]  alu_op3,
   output logic [3:0]  alu_d,
   output logic        alu_reset,
   output logic [2:0]  rf_ra1,
   output logic [2:0]  rf_ra2,
   output logic [2:0]  rf_wa,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        mem_re,
   output logic        mem_we,
   output logic        out_en,
   output logic [3:0]  szcv,
   output logic        branch_taken,
   output logic        halted
);

   phase_e      state_r;
   phase_e      state_nxt_s;
   logic [15:0] pc_r;
   logic [15:0] ir_r;
   logic [3:0]  szcv_r;

   logic        fetch_go_s;
   logic [1:0]  op1_s;
   logic [3:0]  op3_s;
   logic [2:0]  sub_s;
   logic        is_alu_s;
   logic        is_ld_s;
   logic        is_st_s;
   logic        is_br_s;
   logic        is_li_s;
   logic        is_hlt_s;
   logic        cond_taken_s;
   logic        taken_s;
   logic        rf_write_s;
   logic [15:0] br_offset_s;

`ifdef IMEM_WAIT_EN
   assign fetch_go_s = imem_ready;
`else
   assign fetch_go_s = 1'b1;
`endif

   assign op1_s    = ir_r[15:14];
   assign op3_s    = ir_r[7:4];
   assign sub_s    = ir_r[13:11];
   assign is_alu_s = (op1_s == OP1_ALU);
   assign is_ld_s  = (op1_s == OP1_LD);
   assign is_st_s  = (op1_s == OP1_ST);
   assign is_br_s  = (op1_s == OP1_BR);
   assign is_li_s  = is_br_s && (sub_s == BR_LI);
   assign is_hlt_s = is_alu_s && (op3_s == OP3_HLT);

   simple_branch_cond u_branch_cond (
      .szcv  (szcv_r),
      .cond  (ir_r[10:8]),
      .taken (cond_taken_s)
   );

   assign taken_s     = is_br_s && ((sub_s == BR_B) || ((sub_s == BR_BCC) && cond_taken_s));
   assign rf_write_s  = is_ld_s || is_li_s || (is_alu_s && op3_sets_flags(op3_s) && op3_writes_rf(op3_s))
                        || (is_alu_s && (op3_s == OP3_IN));
   assign br_offset_s = {{8{ir_r[7]}}, ir_r[7:0]};

   // Phase sequencing; HLT diverts to HALT at the end of P2.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         PH_P1: begin
            if (fetch_go_s) state_nxt_s = PH_P2;
            else            state_nxt_s = PH_P1;
         end
         PH_P2: begin
            if (is_hlt_s) state_nxt_s = PH_HALT;
            else          state_nxt_s = PH_P3;
         end
         PH_P3:   state_nxt_s = PH_P4;
         PH_P4:   state_nxt_s = PH_P5;
         PH_P5:   state_nxt_s = PH_P1;
         PH_HALT: begin
            if (run_i) state_nxt_s = PH_P1;
            else       state_nxt_s = PH_HALT;
         end
         default: state_nxt_s = PH_P1;
      endcase
   end

   // Architectural state: phase, pc, ir and the flag register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= PH_P1;
         pc_r    <= PC_RESET;
         ir_r    <= 16'h0000;
         szcv_r  <= 4'b0000;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == PH_P1) && fetch_go_s) begin
            ir_r <= imem_rdata;
            pc_r <= pc_r + 16'd1;
         end else if ((state_r == PH_P5) && taken_s) begin
            pc_r <= pc_r + br_offset_s;
         end
         if ((state_r == PH_P3) && is_alu_s && op3_sets_flags(op3_s)) begin
            szcv_r <= alu_szcv;
         end
      end
   end

   // Strobes decode from registered state only, so reset clears them at once.
   always_comb begin
      if (is_alu_s && (op3_s == OP3_IN)) wb_sel = WB_IN;
      else if (is_ld_s)                   wb_sel = WB_MEM;
      else if (is_li_s)                   wb_sel = WB_IMM;
      else                                wb_sel = WB_ALU;
   end

   assign pc           = pc_r;
   assign ir           = ir_r;
   assign szcv         = szcv_r;
   assign phase        = state_r;
   assign halted       = (state_r == PH_HALT);
   assign alu_op1      = op1_s;
   assign alu_op3      = is_alu_s ? op3_s : 4'b0000;
   assign alu_d        = is_alu_s ? ir_r[3:0] : 4'b0000;
   assign alu_reset    = (state_r == PH_P3);
   assign rf_ra1       = ir_r[10:8];
   assign rf_ra2       = ir_r[13:11];
   assign rf_wa        = is_ld_s ? ir_r[13:11] : ir_r[10:8];
   assign rf_we        = (state_r == PH_P5) && rf_write_s;
   assign mem_re       = (state_r == PH_P4) && is_ld_s;
   assign mem_we       = (state_r == PH_P4) && is_st_s;
   assign out_en       = (state_r == PH_P5) && is_alu_s && (op3_s == OP3_OUT);
   assign branch_taken = (state_r == PH_P5) && taken_s;

endmodule

// File: tb/tb_simple_phase_ctrl.sv
// Directed plus randomized bench for simple_phase_ctrl against an
// instruction-level reference model (pc, flags, per-phase expectations).
module tb_simple_phase_ctrl;

   localparam logic [15:0] PC_RESET = 16'h0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic [3:0]  alu_szcv;
   logic        run_i;
   logic [15:0] pc;
   logic [15:0] ir;
   logic [4:0]  phase;
   logic [1:0]  alu_op1;
   logic [3:0]  alu_op3;
   logic [3:0]  alu_d;
   logic        alu_reset;
   logic [2:0]  rf_ra1;
   logic [2:0]  rf_ra2;
   logic [2:0]  rf_wa;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        mem_re;
   logic        mem_we;
   logic        out_en;
   logic [3:0]  szcv;
   logic        branch_taken;
   logic        halted;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_pc;
   logic [3:0]  m_szcv;
   logic [15:0] m_ir;
   // Bit n set: op3 code n updates flags / writes the register file.
   logic [15:0] flag_ops = 16'h0F7F;
   logic [15:0] rf_ops   = 16'h1F5F;

   simple_phase_ctrl #(.PC_RESET(PC_RESET)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_rdata   (imem_rdata),
`ifdef IMEM_WAIT_EN
      .imem_ready   (imem_ready),
`endif
      .alu_szcv     (alu_szcv),
      .run_i        (run_i),
      .pc           (pc),
      .ir           (ir),
      .phase        (phase),
      .alu_op1      (alu_op1),
      .alu_op3      (alu_op3),
      .alu_d        (alu_d),
      .alu_reset    (alu_reset),
      .rf_ra1       (rf_ra1),
      .rf_ra2       (rf_ra2),
      .rf_wa        (rf_wa),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .mem_re       (mem_re),
      .mem_we       (mem_we),
      .out_en       (out_en),
      .szcv         (szcv),
      .branch_taken (branch_taken),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] strobes();
      return {10'b0, alu_reset, rf_we, mem_re, mem_we, out_en, branch_taken};
   endfunction

   function automatic bit model_taken(input logic [15:0] i, input logic [3:0] f);
      bit s, z, v;
      s = f[3]; z = f[2]; v = f[0];
      if (i[13:11] == 3'b100) return 1'b1;
      if (i[13:11] != 3'b111) return 1'b0;
      case (i[10:8])
         3'd0:    return z;
         3'd1:    return s != v;
         3'd2:    return z || (s != v);
         3'd3:    return !z;
         default: return 1'b0;
      endcase
   endfunction

   // One full instruction starting in P1; optionally resets during P4.
   task automatic exec(input logic [15:0] instr, input logic [3:0] flags, input bit abort_p4);
      logic [1:0] op1;
      logic [3:0] op3;
      bit is_alu, is_ld, is_st, is_br, is_li, we, tk;
      logic [1:0] wsel;
      op1    = instr[15:14];
      op3    = instr[7:4];
      is_alu = (op1 == 2'b11);
      is_ld  = (op1 == 2'b00);
      is_st  = (op1 == 2'b01);
      is_br  = (op1 == 2'b10);
      is_li  = is_br && (instr[13:11] == 3'b000);

      chk("p1_phase", {11'b0, phase}, 16'h0001);
      chk("p1_pc", pc, m_pc);
      chk("p1_strobes", strobes(), 16'h0000);
      imem_rdata = instr;
      alu_szcv   = 4'($urandom);
      step();
      m_pc = m_pc + 16'd1;
      m_ir = instr;
      chk("p2_phase", {11'b0, phase}, 16'h0002);
      chk("p2_ir", ir, instr);
      chk("p2_pc", pc, m_pc);
      chk("p2_strobes", strobes(), 16'h0000);
      imem_rdata = 16'($urandom);
      step();
      if (is_alu && op3 == 4'hF) begin
         chk("hlt_phase", {11'b0, phase}, 16'h0000);
         chk("hlt_halted", {15'b0, halted}, 16'h0001);
         chk("hlt_pc", pc, m_pc);
         chk("hlt_strobes", strobes(), 16'h0000);
         return;
      end
      chk("p3_phase", {11'b0, phase}, 16'h0004);
      chk("p3_strobes", strobes(), 16'h0020);
      chk("p3_op1", {14'b0, alu_op1}, {14'b0, op1});
      chk("p3_op3", {12'b0, alu_op3}, is_alu ? {12'b0, op3} : 16'h0000);
      chk("p3_d", {12'b0, alu_d}, is_alu ? {12'b0, instr[3:0]} : 16'h0000);
      chk("p3_ra2", {13'b0, rf_ra2}, {13'b0, instr[13:11]});
      if (!is_br) chk("p3_ra1", {13'b0, rf_ra1}, {13'b0, instr[10:8]});
      alu_szcv = flags;
      step();
      if (is_alu && flag_ops[op3]) m_szcv = flags;
      chk("p4_phase", {11'b0, phase}, 16'h0008);
      chk("p4_strobes", strobes(), {14'b0, is_ld, is_st} << 2);
      chk("p4_szcv", {12'b0, szcv}, {12'b0, m_szcv});
      alu_szcv = 4'($urandom);
      if (abort_p4) begin
         reset = 1'b0;
         #1;
         m_pc = PC_RESET; m_szcv = 4'h0; m_ir = 16'h0000;
         chk("abort_strobes", strobes(), 16'h0000);
         chk("abort_pc", pc, PC_RESET);
         chk("abort_phase", {11'b0, phase}, 16'h0001);
         chk("abort_ir", ir, 16'h0000);
         chk("abort_szcv", {12'b0, szcv}, 16'h0000);
         step();
         reset = 1'b1;
         return;
      end
      step();
      we   = is_ld || is_li || (is_alu && rf_ops[op3]);
      wsel = (is_alu && op3 == 4'hC) ? 2'b11 : is_ld ? 2'b01 : is_li ? 2'b10 : 2'b00;
      tk   = is_br && model_taken(instr, m_szcv);
      chk("p5_phase", {11'b0, phase}, 16'h0010);
      chk("p5_strobes", strobes(),
          {10'b0, 1'b0, we, 2'b00, (is_alu && op3 == 4'hD), tk});
      chk("p5_wb_sel", {14'b0, wb_sel}, {14'b0, wsel});
      if (we) chk("p5_wa", {13'b0, rf_wa}, {13'b0, is_ld ? instr[13:11] : instr[10:8]});
      step();
      if (tk) m_pc = m_pc + {{8{instr[7]}}, instr[7:0]};
      chk("next_pc", pc, m_pc);
   endtask

   initial begin
      logic [15:0] ins;
      reset      = 1'b0;
      imem_rdata = 16'h0000;
      imem_ready = 1'b1;
      alu_szcv   = 4'h0;
      run_i      = 1'b0;
      m_pc = PC_RESET; m_szcv = 4'h0; m_ir = 16'h0000;
      step();
      step();
      chk("rst_pc", pc, PC_RESET);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_phase", {11'b0, phase}, 16'h0001);
      chk("rst_szcv", {12'b0, szcv}, 16'h0000);
      chk("rst_halted", {15'b0, halted}, 16'h0000);
      chk("rst_strobes", strobes(), 16'h0000);
      reset = 1'b1;

      exec(16'hD100, 4'($urandom), 1'b0);
      chk("add_pc_after", pc, 16'h0001);

      // Backward branch underflow, then increment wrap at 16'hFFFF.
      exec(16'hA080, 4'($urandom), 1'b0);
      chk("underflow_pc", pc, 16'hFF82);
      exec(16'hA07C, 4'($urandom), 1'b0);
      chk("ffff_pc", pc, 16'hFFFF);
      exec({5'b10000, 3'($urandom), 8'($urandom)}, 4'($urandom), 1'b0);
      chk("wrap_pc", pc, 16'h0000);

      exec({2'b11, 6'($urandom), 4'b0001, 4'($urandom)}, 4'b0100, 1'b0);
      exec(16'hB8FC, 4'($urandom), 1'b0);
      exec({2'b11, 6'($urandom), 4'b0101, 4'($urandom)}, 4'b1001, 1'b0);
      exec({8'b10111001, 8'($urandom)}, 4'($urandom), 1'b0);
      exec({2'b11, 6'($urandom), 4'b0010, 4'($urandom)}, 4'b1000, 1'b0);
      exec({8'b10111010, 8'($urandom)}, 4'($urandom), 1'b0);
      exec({2'b00, 14'($urandom)}, 4'($urandom), 1'b0);
      run_i = 1'b1;
      exec({2'b01, 14'($urandom)}, 4'($urandom), 1'b0);
      run_i = 1'b0;

`ifdef IMEM_WAIT_EN
      imem_ready = 1'b0;
      for (int w = 0; w < 3; w++) begin
         imem_rdata = 16'($urandom);
         step();
         chk("wait_phase", {11'b0, phase}, 16'h0001);
         chk("wait_pc", pc, m_pc);
         chk("wait_ir", ir, m_ir);
      end
      imem_ready = 1'b1;
      exec(16'hD100, 4'($urandom), 1'b0);
`endif

      for (int n = 0; n < 24; n++) begin
         ins = 16'($urandom);
         if (ins[15:14] == 2'b11 && ins[7:4] == 4'hF) ins[7:4] = 4'hE;
         exec(ins, 4'($urandom), 1'b0);
      end

      exec({2'b11, 6'($urandom), 4'b1111, 4'($urandom)}, 4'($urandom), 1'b0);
      for (int h = 0; h < 3; h++) begin
         imem_rdata = 16'($urandom);
         step();
         chk("halt_hold_phase", {11'b0, phase}, 16'h0000);
         chk("halt_hold_pc", pc, m_pc);
         chk("halt_hold_flag", {15'b0, halted}, 16'h0001);
      end
      run_i = 1'b1;
      step();
      run_i = 1'b0;
      chk("resume_phase", {11'b0, phase}, 16'h0001);
      chk("resume_halted", {15'b0, halted}, 16'h0000);
      chk("resume_szcv", {12'b0, szcv}, {12'b0, m_szcv});
      exec({2'b11, 6'($urandom), 4'b0011, 4'($urandom)}, 4'($urandom), 1'b0);

      exec({2'b01, 14'($urandom)}, 4'($urandom), 1'b1);
      exec(16'hD100, 4'($urandom), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
